// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter with a valid/ready load, LSB- or MSB-first
// Ports: clk; reset_n (asynchronous, active-low);
//        load_valid/load_ready/load_data/load_dir: word handshake, captured on accept;
//        serial_out/serial_valid: current frame bit and its qualifier;
//        busy: frame in progress; done: one-cycle pulse the cycle after the last frame bit.
// Build option: define PISO_PARITY_EN to append an even-parity bit (^data) to every frame.
module piso_serializer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    input  logic         load_dir,
    output logic         serial_out,
    output logic         serial_valid,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    state_t        state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          done_q, done_d;
`ifdef PISO_PARITY_EN
    logic          par_q, par_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = SHIFT;
                    sreg_d  = load_data;
                    dir_d   = load_dir;
                    cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    par_d   = ^load_data;
`endif
                end
            end
            SHIFT: begin
                // The outgoing bit always sits at the end selected by dir, so shift toward it.
                sreg_d = dir_q ? sreg_q << 1 : sreg_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign load_ready   = state_q == IDLE;
    assign busy         = state_q != IDLE;
    assign serial_valid = state_q != IDLE;
    assign done         = done_q;
`ifdef PISO_PARITY_EN
    assign serial_out   = (state_q == SHIFT) ? (dir_q ? sreg_q[N-1] : sreg_q[0])
                                             : ((state_q == PARITY) & par_q);
`else
    assign serial_out   = (state_q == SHIFT) ? (dir_q ? sreg_q[N-1] : sreg_q[0]) : 1'b0;
`endif
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized scoreboard bench for piso_serializer with a loopback receiver model
module tb_piso_serializer;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_data;
    logic         load_dir;
    logic         serial_out;
    logic         serial_valid;
    logic         busy;
    logic         done;

    piso_serializer #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dir(load_dir),
        .serial_out(serial_out), .serial_valid(serial_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         b;
        logic         last;
        logic         rx_check;
        logic         is_data;
        logic         dir;
        logic [N-1:0] word;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    logic         exp_done = 1'b0;
    logic [N-1:0] rx = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected frame: data bits in the order the direction dictates, optionally followed by parity.
    task automatic push_frame(input logic [N-1:0] d, input logic dir);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.b        = dir ? d[N-1-i] : d[i];
            e.is_data  = 1'b1;
            e.rx_check = (i == N - 1);
            e.dir      = dir;
            e.word     = d;
`ifdef PISO_PARITY_EN
            e.last     = 1'b0;
`else
            e.last     = (i == N - 1);
`endif
            q.push_back(e);
        end
`ifdef PISO_PARITY_EN
        e.b        = ^d;
        e.is_data  = 1'b0;
        e.rx_check = 1'b0;
        e.last     = 1'b1;
        q.push_back(e);
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            chk("rst_sout", serial_out, 0);
            chk("rst_svalid", serial_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ready", load_ready, 1);
            exp_done = 1'b0;
        end else begin
            chk("done", done, exp_done);
            chk("svalid", serial_valid, q.size() != 0);
            chk("busy", busy, q.size() != 0);
            chk("ready", load_ready, q.size() == 0);
            if (exp_done) chk("done_sout", serial_out, 0);
            exp_done = 1'b0;
            if (serial_valid && q.size() != 0) begin
                e = q.pop_front();
                chk("sout", serial_out, e.b);
                if (e.is_data)
                    rx = e.dir ? {rx[N-2:0], serial_out} : {serial_out, rx[N-1:1]};
                if (e.rx_check) chk("loopback", rx, e.word);
                if (e.last) exp_done = 1'b1;
            end
        end
    end

    // Drive one cycle of inputs from posedge+2; returns whether the DUT took the word.
    task automatic cycle(input logic v, input logic [N-1:0] d, input logic dir, output logic acc);
        logic rdy;
        load_valid = v;
        load_data  = d;
        load_dir   = dir;
        rdy        = load_ready;
        @(posedge clk);
        #1;
        acc = v && rdy && reset_n;
        if (acc) push_frame(d, dir);
        #1;
    endtask

    task automatic send(input logic [N-1:0] d, input logic dir);
        logic acc = 1'b0;
        for (int t = 0; t < 3 * N + 8 && !acc; t++) cycle(1'b1, d, dir, acc);
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: got not-accepted expected accepted at %0t", $time);
        end
        load_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int t = 0; t < n; t++) cycle(1'b0, 4'($urandom), 1'($urandom), acc);
    endtask

    task automatic mid_reset;
        reset_n = 1'b0;
        #1;
        chk("async_sout", serial_out, 0);
        chk("async_svalid", serial_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", load_ready, 1);
        q.delete();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic acc;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_dir   = 1'b0;
        #1;
        chk("init_ready", load_ready, 1);
        chk("init_svalid", serial_valid, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        send(4'b1011, 1'b0);
        idle(N + 4);
        send(4'b1011, 1'b1);
        idle(N + 4);
        send(4'b0011, 1'b0);
        idle(N + 4);

        // Valid held high: second word must wait and be taken in the done cycle.
        cycle(1'b1, 4'b0110, 1'b0, acc);
        chk("held_first_acc", acc, 1);
        send(4'b1001, 1'b0);
        idle(N + 4);

        // Abort during bit 2 of an all-ones frame.
        send(4'b1111, 1'b0);
        idle(2);
        mid_reset();
        idle(N + 4);

        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(99) == 0) mid_reset();
            else cycle(1'($urandom_range(9) < 7), 4'($urandom), 1'($urandom), acc);
        end
        load_valid = 1'b0;
        idle(N + 4);
        chk("drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
